// File: rtl/rvl_vio_slave_pkg.sv
// rvl_vio_pkg: shared encodings for the JTAG virtual-I/O responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: frame opcodes, control FSM states, synchronizer pin map, frame width helper.
package rvl_vio_pkg;

  // Two-bit opcode carried in the low bits of every frame.
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_PULSE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    EXEC  = 2'b10
  } state_e;

  // Synchronizer bit map. The edge-detected pins sit in the low EDGE_W bits
  // so the generic synchronizer can add its third stage to those bits only.
  localparam int PIN_W     = 7;
  localparam int EDGE_W    = 2;
  localparam int PIN_TCK   = 0;
  localparam int PIN_UPD   = 1;
  localparam int PIN_TDI   = 2;
  localparam int PIN_SHIFT = 3;
  localparam int PIN_RSTN  = 4;
  localparam int PIN_CE2   = 5;
  localparam int PIN_IPEN  = 6;

  // Frame = data field + address field + 2-bit opcode.
  function automatic int frame_w(input int data_w, input int addr_w);
    return data_w + addr_w + 2;
  endfunction

endpackage

// File: rtl/rvl_vio_slave_if.sv
// rvl_vio_slave_if: jtagconn16 ER2 port bundle between the hub and a VIO responder.
// Latency: n/a (wires only).
// Backpressure: none; the host paces everything through jtck.
// Signals: jtck/jtdi/jshift/jupdate/jrstn/jce2/ip_enable hub->IP, er2_tdo IP->hub.
interface rvl_vio_slave_if;
  logic jtck;
  logic jtdi;
  logic jshift;
  logic jupdate;
  logic jrstn;
  logic jce2;
  logic ip_enable;
  logic er2_tdo;

  modport master (
    output jtck, jtdi, jshift, jupdate, jrstn, jce2, ip_enable,
    input  er2_tdo
  );

  modport slave (
    input  jtck, jtdi, jshift, jupdate, jrstn, jce2, ip_enable,
    output er2_tdo
  );
endinterface

// File: rtl/rvl_jtag_sync.sv
// rvl_jtag_sync: N-bit 2-flop synchronizer; the low E bits get a third flop for rise detection.
// Latency: level outputs 2 clk after the pin; rise_o is high in the 3rd clk so its action lands on the 3rd edge.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), d_i async pins, s_o synced levels of bits [N-1:E], rise_o rising edges of bits [E-1:0].
module rvl_jtag_sync #(
  parameter int N = 7,
  parameter int E = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d_i,
  output logic [N-1:E] s_o,
  output logic [E-1:0] rise_o
);

  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [E-1:0] s3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q[E-1:0];
    end
  end

  assign s_o    = s2_q[N-1:E];
  assign rise_o = s2_q[E-1:0] & ~s3_q;

endmodule

// File: rtl/rvl_vio_slave.sv
// rvl_vio_slave: JTAG virtual I/O responder - host writes vout words, fires pulses, reads vin probes.
// Latency: a JTAG pin event acts on the 3rd clk edge after the pin changes; WRITE visible the clk after that.
// Backpressure: none; clk must run at >=4x jtck so no host edge is missed.
// Ports: clk, reset (sync, active-high), jtag (ER2 slave modport, carries er2_tdo),
//        vin/vout (NUM_REGS words of DATA_W, word k at [k*DATA_W +: DATA_W]), vout_pulse, frame_err (sticky).
module rvl_vio_slave
  import rvl_vio_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  rvl_vio_slave_if.slave             jtag,
  input  logic [NUM_REGS*DATA_W-1:0] vin,
  output logic [NUM_REGS*DATA_W-1:0] vout,
  output logic [NUM_REGS-1:0]        vout_pulse,
  output logic                       frame_err
);

  localparam int FRAME_W = frame_w(DATA_W, ADDR_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  // ---------------------------------------------------------------
  // Pin synchronization (all pins oversampled in the clk domain)
  // ---------------------------------------------------------------
  logic [PIN_W-1:0]      pins;
  logic [PIN_W-1:EDGE_W] lvl_s;
  logic [EDGE_W-1:0]     rise_s;

  assign pins = {jtag.ip_enable, jtag.jce2, jtag.jrstn, jtag.jshift,
                 jtag.jtdi, jtag.jupdate, jtag.jtck};

  rvl_jtag_sync #(.N(PIN_W), .E(EDGE_W)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pins),
    .s_o    (lvl_s),
    .rise_o (rise_s)
  );

  logic tck_rise, upd_rise, jtdi_s, jshift_s, jrstn_s, sel_s;
  logic shift_en, upd_en;

  assign tck_rise = rise_s[PIN_TCK];
  assign upd_rise = rise_s[PIN_UPD];
  assign jtdi_s   = lvl_s[PIN_TDI];
  assign jshift_s = lvl_s[PIN_SHIFT];
  assign jrstn_s  = lvl_s[PIN_RSTN];
  assign sel_s    = lvl_s[PIN_CE2] & lvl_s[PIN_IPEN];

  assign shift_en = tck_rise & sel_s & jshift_s;
  // Update outranks shift when both edges arrive together.
  assign upd_en   = upd_rise & sel_s;

  // ---------------------------------------------------------------
  // State
  // ---------------------------------------------------------------
  state_e                           state_q;
  logic [FRAME_W-1:0]               sr_q, sr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic                             tdo_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  vout_q;
  logic [NUM_REGS-1:0][DATA_W-1:0]  vin_w;
  logic [NUM_REGS-1:0]              pulse_q;
  logic                             ferr_q;

  // Frame fields as seen at update time.
  op_e               op_f;
  logic [ADDR_W-1:0] addr_f;
  logic [DATA_W-1:0] data_f;

  assign op_f   = op_e'(sr_q[1:0]);
  assign addr_f = sr_q[ADDR_W+1:2];
  assign data_f = sr_q[FRAME_W-1:ADDR_W+2];
  assign vin_w  = vin;

  // Shift register / bit counter next state.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (!jrstn_s) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (upd_en) begin
      cnt_d = '0;
      // READ reloads the shifter with the probe so the next scan returns it.
      if (cnt_q == CNT_FULL && op_f == OP_READ) begin
        sr_d = {vin_w[addr_f], addr_f, OP_READ};
      end
    end else if (shift_en) begin
      sr_d = {jtdi_s, sr_q[FRAME_W-1:1]};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      tdo_q   <= 1'b0;
      vout_q  <= '0;
      pulse_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      // TDO tracks the shifter LSB from a flop so it is settled long
      // before the host samples it.
      tdo_q   <= sr_d[0];
      pulse_q <= '0;
      if (!jrstn_s) begin
        state_q <= IDLE;
      end else if (upd_en) begin
        if (cnt_q != CNT_FULL) begin
          ferr_q  <= 1'b1;
          state_q <= IDLE;
        end else begin
          state_q <= EXEC;
          case (op_f)
            OP_NOP:   ferr_q <= 1'b0;
            OP_WRITE: vout_q[addr_f] <= data_f;
            OP_READ:  ;
            OP_PULSE: pulse_q[addr_f] <= 1'b1;
          endcase
        end
      end else if (shift_en) begin
        state_q <= SHIFT;
      end else if (state_q == EXEC) begin
        state_q <= IDLE;
      end
    end
  end

  assign vout         = vout_q;
  assign vout_pulse   = pulse_q;
  assign frame_err    = ferr_q;
  assign jtag.er2_tdo = tdo_q;

endmodule

// File: tb/tb_rvl_vio_slave.sv
// tb_rvl_vio_slave: directed bench for the JTAG virtual I/O responder.
// Latency: n/a. Backpressure: n/a.
// A frame-level model tracks expected outputs every cycle; literal checks pin the key results.
module tb_rvl_vio_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] vin;
  logic [31:0] vout;
  logic [3:0]  vout_pulse;
  logic        frame_err;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  rvl_vio_slave_if jif ();

  rvl_vio_slave #(.DATA_W(8), .NUM_REGS(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .jtag       (jif),
    .vin        (vin),
    .vout       (vout),
    .vout_pulse (vout_pulse),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pin view: bit0 tck, 1 update, 2 tdi, 3 shift, 4 rstn, 5 ce2, 6 ip_enable.
  // A pin change becomes effective on the 3rd clk edge, so each edge acts on
  // the sample taken two edges earlier, compared with the one before it.
  logic [6:0] h [0:3];
  logic [6:0] s, p;
  int         m_sr, m_cnt, m_op, m_addr, m_data;
  logic       m_ferr;
  logic [7:0] m_vout [0:3];
  logic [3:0] m_pulse;

  always @(posedge clk) begin
    m_pulse = 4'd0;
    if (reset) begin
      m_sr = 0; m_cnt = 0; m_ferr = 1'b0;
      for (int i = 0; i < 4; i++) begin
        m_vout[i] = 8'd0;
        h[i] = 7'd0;
      end
    end else begin
      h[3] = h[2]; h[2] = h[1]; h[1] = h[0];
      h[0] = {jif.ip_enable, jif.jce2, jif.jrstn, jif.jshift, jif.jtdi, jif.jupdate, jif.jtck};
      s = h[2];
      p = h[3];
      if (!s[4]) begin
        m_sr = 0; m_cnt = 0;
      end else if (s[1] && !p[1] && s[5] && s[6]) begin
        if (m_cnt != 12) begin
          m_ferr = 1'b1;
        end else begin
          m_op   = m_sr % 4;
          m_addr = (m_sr / 4) % 4;
          m_data = m_sr / 16;
          case (m_op)
            0: m_ferr = 1'b0;
            1: m_vout[m_addr] = m_data[7:0];
            2: m_sr = int'(vin[m_addr*8 +: 8]) * 16 + m_addr * 4 + 2;
            default: m_pulse = 4'd1 << m_addr;
          endcase
        end
        m_cnt = 0;
      end else if (s[0] && !p[0] && s[3] && s[5] && s[6]) begin
        m_sr = (m_sr / 2) + (s[2] ? 2048 : 0);
        if (m_cnt < 13) m_cnt = m_cnt + 1;
      end
    end
  end

  logic [31:0] exp_vout;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_vout = {m_vout[3], m_vout[2], m_vout[1], m_vout[0]};
      checks++;
      if (vout !== exp_vout || vout_pulse !== m_pulse ||
          frame_err !== m_ferr || jif.er2_tdo !== m_sr[0]) begin
        errors++;
        $display("FAIL model_cycle t=%0t vout=%h exp %h pulse=%b exp %b ferr=%b exp %b tdo=%b exp %b",
                 $time, vout, exp_vout, vout_pulse, m_pulse, frame_err, m_ferr, jif.er2_tdo, m_sr[0]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One jtck period: 4 clk low with tdi set up, 4 clk high. TDO is sampled
  // just before the rising edge, as the host would.
  task automatic tck_bit(input logic b, output logic tdo);
    jif.jtdi = b;
    wait_clk(4);
    tdo = jif.er2_tdo;
    jif.jtck = 1'b1;
    wait_clk(4);
    jif.jtck = 1'b0;
  endtask

  task automatic shift_frame(input logic [11:0] f, input int n, output logic [11:0] seq);
    logic t;
    seq = 12'd0;
    jif.jshift = 1'b1;
    for (int i = 0; i < n; i++) begin
      tck_bit(f[i], t);
      seq[i] = t;
    end
    jif.jshift = 1'b0;
    wait_clk(2);
  endtask

  task automatic do_update();
    jif.jupdate = 1'b1;
    wait_clk(4);
    jif.jupdate = 1'b0;
    wait_clk(6);
  endtask

  task automatic jrstn_pulse();
    jif.jrstn = 1'b0;
    wait_clk(8);
    jif.jrstn = 1'b1;
    wait_clk(4);
  endtask

  // ---------------- directed sequence ----------------
  logic [11:0] seq;
  logic        tb_t;
  int          hits, bad;

  initial begin
    reset = 1'b1;
    vin = 32'd0;
    jif.jtck = 1'b0; jif.jtdi = 1'b0; jif.jshift = 1'b0; jif.jupdate = 1'b0;
    jif.jrstn = 1'b1; jif.jce2 = 1'b1; jif.ip_enable = 1'b1;
    wait_clk(3);
    chk_en = 1'b1;
    check("reset_vout", vout, 32'd0);
    check("reset_pulse", {28'd0, vout_pulse}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_tdo", {31'd0, jif.er2_tdo}, 32'd0);
    reset = 1'b0;
    wait_clk(4);

    // WRITE data=A5 addr=2
    shift_frame(12'hA59, 12, seq);
    do_update();
    check("write_vout", vout, 32'h00A5_0000);
    check("write_ferr", {31'd0, frame_err}, 32'd0);

    // READ addr=1 with probe 0x3C, then scan it out with zeros
    vin = 32'h0000_3C00;
    shift_frame(12'h006, 12, seq);
    do_update();
    shift_frame(12'h000, 12, seq);
    check("read_tdo_seq", {20'd0, seq}, 32'h0000_03C6);
    do_update();   // the all-zero scan is itself a NOP frame
    check("read_nop_ferr", {31'd0, frame_err}, 32'd0);

    // PULSE addr=3: exactly one clk of 4'b1000
    shift_frame(12'h00F, 12, seq);
    hits = 0; bad = 0;
    jif.jupdate = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (vout_pulse == 4'b1000) hits++;
      else if (vout_pulse != 4'b0000) bad++;
    end
    jif.jupdate = 1'b0;
    wait_clk(6);
    check("pulse_hits", hits, 32'd1);
    check("pulse_bad", bad, 32'd0);
    check("pulse_vout", vout, 32'h00A5_0000);

    // Short frame flags an error and has no side effect; NOP clears it
    shift_frame(12'hFF1, 11, seq);
    do_update();
    check("short_ferr", {31'd0, frame_err}, 32'd1);
    check("short_vout", vout, 32'h00A5_0000);
    shift_frame(12'h000, 12, seq);
    do_update();
    check("nop_clears_ferr", {31'd0, frame_err}, 32'd0);

    // jrstn mid-frame discards the partial frame, keeps vout
    shift_frame(12'hABC, 6, seq);
    check("jrstn_vout_kept_pre", vout, 32'h00A5_0000);
    jrstn_pulse();
    shift_frame(12'h5A1, 12, seq);
    do_update();
    check("jrstn_write_vout", vout, 32'h00A5_005A);
    check("jrstn_ferr", {31'd0, frame_err}, 32'd0);

    // ip_enable low: whole transaction ignored, TDO stays low
    jrstn_pulse();
    check("tdo_after_jrstn", {31'd0, jif.er2_tdo}, 32'd0);
    jif.ip_enable = 1'b0;
    wait_clk(4);
    shift_frame(12'h775, 12, seq);
    do_update();
    check("noen_vout", vout, 32'h00A5_005A);
    check("noen_tdo_seq", {20'd0, seq}, 32'd0);
    check("noen_ferr", {31'd0, frame_err}, 32'd0);
    jif.ip_enable = 1'b1;
    wait_clk(4);

    // Synchronous reset mid-shift clears every output next cycle
    shift_frame(12'h123, 11, seq);
    do_update();
    check("pre_reset_ferr", {31'd0, frame_err}, 32'd1);
    jif.jshift = 1'b1;
    for (int i = 0; i < 3; i++) tck_bit(1'b1, tb_t);
    reset = 1'b1;
    wait_clk(1);
    check("rst_vout", vout, 32'd0);
    check("rst_pulse", {28'd0, vout_pulse}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_tdo", {31'd0, jif.er2_tdo}, 32'd0);
    reset = 1'b0;
    jif.jshift = 1'b0;
    wait_clk(10);

    // After reset a clean WRITE still works (no stale bit count)
    shift_frame(12'h3C5, 12, seq);
    do_update();
    check("post_reset_write", vout, 32'h0000_3C00);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
